// File: rtl/nand3_resp_check.sv
// Response checker for a NAND3 cell and its two load taps.
// Ports: Clock/Reset, vec_valid/vec_ready handshake, A/B/C in, Y/Yld0/Yld1 observed, stats out.
module nand3_resp_check #(
  parameter int SETTLE = 4,
  parameter int CNT_W  = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             Y,
  input  logic             Yld0,
  input  logic             Yld1,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             mismatch,
  output logic             first_fail,
  output logic [2:0]       first_vec,
  output logic             busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;

  localparam logic [7:0] SET_LD = 8'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [2:0]       vec_q, vec_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic             mis_q, mis_d;
  logic             ff_q, ff_d;
  logic [2:0]       fv_q, fv_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;

  logic exp_y;
  logic fail;

  assign exp_y = ~&vec_q;

  // X/Z on any observed output must count as a miss,
  // hence the case-inequality.
  assign fail = (Y    !== exp_y) |
                (Yld0 !== exp_y) |
                (Yld1 !== exp_y);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    vcnt_d  = vcnt_q;
    ecnt_d  = ecnt_q;
    mis_d   = 1'b0;
    ff_d    = ff_q;
    fv_d    = fv_q;
    unique case (state_q)
      S_IDLE: begin
        if (vec_valid) begin
          vec_d   = {A, B, C};
          cnt_d   = SET_LD;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_SAMPLE: begin
        if (vcnt_q != CMAX) begin
          vcnt_d = vcnt_q + 1'b1;
        end
        if (fail) begin
          mis_d = 1'b1;
          if (ecnt_q != CMAX) begin
            ecnt_d = ecnt_q + 1'b1;
          end
          if (!ff_q) begin
            ff_d = 1'b1;
            fv_d = vec_q;
          end
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Handshake flags are registered copies of the next state.
    rdy_d  = (state_d == S_IDLE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      vec_q   <= 3'b000;
      vcnt_q  <= '0;
      ecnt_q  <= '0;
      mis_q   <= 1'b0;
      ff_q    <= 1'b0;
      fv_q    <= 3'b000;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      vcnt_q  <= vcnt_d;
      ecnt_q  <= ecnt_d;
      mis_q   <= mis_d;
      ff_q    <= ff_d;
      fv_q    <= fv_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign vec_ready  = rdy_q;
  assign busy       = busy_q;
  assign vec_count  = vcnt_q;
  assign err_count  = ecnt_q;
  assign mismatch   = mis_q;
  assign first_fail = ff_q;
  assign first_vec  = fv_q;

endmodule
